// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, decode and issue, plus the shared op enums.
// Macro ARRISKV_RV32M_EN (see decode_stage) only changes which enum values get used.

typedef enum logic [3:0] {
    CLS_NONE, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
    CLS_LOAD, CLS_STORE, CLS_OP_IMM, CLS_OP, CLS_MISC_MEM, CLS_SYSTEM
} opclass_e;

typedef enum logic [5:0] {
    INS_NOP, INS_LUI, INS_AUIPC, INS_JAL, INS_JALR,
    INS_BEQ, INS_BNE, INS_BLT, INS_BGE, INS_BLTU, INS_BGEU,
    INS_LB, INS_LH, INS_LW, INS_LBU, INS_LHU,
    INS_SB, INS_SH, INS_SW,
    INS_ADDI, INS_SLTI, INS_SLTIU, INS_XORI, INS_ORI, INS_ANDI,
    INS_SLLI, INS_SRLI, INS_SRAI,
    INS_ADD, INS_SUB, INS_SLL, INS_SLT, INS_SLTU, INS_XOR,
    INS_SRL, INS_SRA, INS_OR, INS_AND,
    INS_FENCE, INS_ECALL, INS_EBREAK,
    INS_MUL, INS_MULH, INS_MULHSU, INS_MULHU,
    INS_DIV, INS_DIVU, INS_REM, INS_REMU
} instr_e;

interface decode_stage_if #(
    parameter int XLEN       = 32,
    parameter int N_REGS     = 32,
    parameter int N_RD_PORTS = 2
);
    localparam int RW = $clog2(N_REGS);

    // Register fields keep the raw 5-bit encoding so out-of-range indices stay visible.
    typedef struct packed {
        opclass_e        opclass;
        instr_e          instr;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            uses_rs1;
        logic            uses_rs2;
        logic            writes_rd;
        logic            illegal;
    } op_t;

    logic                             i_valid;
    logic                             o_ready;
    logic [31:0]                      i_instr;
    logic [XLEN-1:0]                  i_pc;
    logic                             o_valid;
    logic                             i_ready;
    op_t                              o_op;
    logic [N_RD_PORTS-1:0][RW-1:0]    o_reg_rd_addr;
    logic                             i_flush;

    modport master (
        output i_valid, i_instr, i_pc, i_ready, i_flush,
        input  o_ready, o_valid, o_op, o_reg_rd_addr
    );

    modport slave (
        input  i_valid, i_instr, i_pc, i_ready, i_flush,
        output o_ready, o_valid, o_op, o_reg_rd_addr
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage with an output register plus one skid register.
// Define ARRISKV_RV32M_EN to decode the M-extension multiply/divide ops.

module decode_stage #(
    parameter int XLEN       = 32,
    parameter int N_REGS     = 32,
    parameter int N_RD_PORTS = 2
) (
    input  logic         clk,
    input  logic         rst,
    decode_stage_if.slave bus
);
    localparam int RW = $clog2(N_REGS);

    typedef struct packed {
        opclass_e        opclass;
        instr_e          instr;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            uses_rs1;
        logic            uses_rs2;
        logic            writes_rd;
        logic            illegal;
    } op_t;

    op_t  outOp_q, outOp_d, skidOp_q, skidOp_d, decOp;
    logic outValid_q, outValid_d, skidValid_q, skidValid_d;
    logic accept, drain;

    logic [31:0]     instr;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [6:0]      shF7;
    logic [XLEN-1:0] immI, immS, immB, immJ, immU;

    assign instr = bus.i_instr;
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    // On RV64 instr[25] belongs to the shift amount, so only the upper six bits qualify the op.
    assign shF7  = (XLEN == 32) ? f7 : {f7[6:1], 1'b0};

    assign immI = XLEN'($signed(instr[31:20]));
    assign immS = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign immB = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign immJ = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign immU = XLEN'($signed({instr[31:12], 12'b0}));

    function automatic logic regOk(input logic [4:0] idx);
        return int'(idx) < N_REGS;
    endfunction

    opclass_e        cls;
    instr_e          ins;
    logic            useRs1, useRs2, hasRd, bad;
    logic [XLEN-1:0] imm;

    always_comb begin
        cls    = CLS_NONE;
        ins    = INS_NOP;
        useRs1 = 1'b0;
        useRs2 = 1'b0;
        hasRd  = 1'b0;
        bad    = 1'b0;
        imm    = '0;
        case (instr[6:0])
            7'b0110111: begin
                cls = CLS_LUI; ins = INS_LUI; hasRd = 1'b1; imm = immU;
            end
            7'b0010111: begin
                cls = CLS_AUIPC; ins = INS_AUIPC; hasRd = 1'b1; imm = immU;
            end
            7'b1101111: begin
                cls = CLS_JAL; ins = INS_JAL; hasRd = 1'b1; imm = immJ;
            end
            7'b1100111: begin
                cls = CLS_JALR; ins = INS_JALR; hasRd = 1'b1; useRs1 = 1'b1; imm = immI;
                bad = (f3 != 3'b000);
            end
            7'b1100011: begin
                cls = CLS_BRANCH; useRs1 = 1'b1; useRs2 = 1'b1; imm = immB;
                case (f3)
                    3'b000:  ins = INS_BEQ;
                    3'b001:  ins = INS_BNE;
                    3'b100:  ins = INS_BLT;
                    3'b101:  ins = INS_BGE;
                    3'b110:  ins = INS_BLTU;
                    3'b111:  ins = INS_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            7'b0000011: begin
                cls = CLS_LOAD; hasRd = 1'b1; useRs1 = 1'b1; imm = immI;
                case (f3)
                    3'b000:  ins = INS_LB;
                    3'b001:  ins = INS_LH;
                    3'b010:  ins = INS_LW;
                    3'b100:  ins = INS_LBU;
                    3'b101:  ins = INS_LHU;
                    default: bad = 1'b1;
                endcase
            end
            7'b0100011: begin
                cls = CLS_STORE; useRs1 = 1'b1; useRs2 = 1'b1; imm = immS;
                case (f3)
                    3'b000:  ins = INS_SB;
                    3'b001:  ins = INS_SH;
                    3'b010:  ins = INS_SW;
                    default: bad = 1'b1;
                endcase
            end
            7'b0010011: begin
                cls = CLS_OP_IMM; hasRd = 1'b1; useRs1 = 1'b1; imm = immI;
                case (f3)
                    3'b000: ins = INS_ADDI;
                    3'b010: ins = INS_SLTI;
                    3'b011: ins = INS_SLTIU;
                    3'b100: ins = INS_XORI;
                    3'b110: ins = INS_ORI;
                    3'b111: ins = INS_ANDI;
                    3'b001: begin
                        if (shF7 == 7'b0000000) ins = INS_SLLI;
                        else                    bad = 1'b1;
                    end
                    default: begin
                        if (shF7 == 7'b0000000)      ins = INS_SRLI;
                        else if (shF7 == 7'b0100000) ins = INS_SRAI;
                        else                         bad = 1'b1;
                    end
                endcase
            end
            7'b0110011: begin
                cls = CLS_OP; hasRd = 1'b1; useRs1 = 1'b1; useRs2 = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  ins = INS_ADD;
                        3'b001:  ins = INS_SLL;
                        3'b010:  ins = INS_SLT;
                        3'b011:  ins = INS_SLTU;
                        3'b100:  ins = INS_XOR;
                        3'b101:  ins = INS_SRL;
                        3'b110:  ins = INS_OR;
                        default: ins = INS_AND;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'b000)      ins = INS_SUB;
                    else if (f3 == 3'b101) ins = INS_SRA;
                    else                   bad = 1'b1;
                end
`ifdef ARRISKV_RV32M_EN
                else if (f7 == 7'b0000001) begin
                    case (f3)
                        3'b000:  ins = INS_MUL;
                        3'b001:  ins = INS_MULH;
                        3'b010:  ins = INS_MULHSU;
                        3'b011:  ins = INS_MULHU;
                        3'b100:  ins = INS_DIV;
                        3'b101:  ins = INS_DIVU;
                        3'b110:  ins = INS_REM;
                        default: ins = INS_REMU;
                    endcase
                end
`endif
                else begin
                    bad = 1'b1;
                end
            end
            7'b0001111: begin
                cls = CLS_MISC_MEM;
                if (f3 == 3'b000) ins = INS_FENCE;
                else              bad = 1'b1;
            end
            7'b1110011: begin
                cls = CLS_SYSTEM;
                if (instr[31:7] == 25'd0)                 ins = INS_ECALL;
                else if (instr[31:7] == {12'h001, 13'd0}) ins = INS_EBREAK;
                else                                      bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        if ((useRs1 && !regOk(instr[19:15])) ||
            (useRs2 && !regOk(instr[24:20])) ||
            (hasRd  && !regOk(instr[11:7]))) begin
            bad = 1'b1;
        end
    end

    // Illegal ops still travel downstream but behave as a NOP with no register traffic.
    always_comb begin
        decOp           = '0;
        decOp.opclass   = cls;
        decOp.instr     = bad ? INS_NOP : ins;
        decOp.rs1       = instr[19:15];
        decOp.rs2       = instr[24:20];
        decOp.rd        = instr[11:7];
        decOp.imm       = imm;
        decOp.pc        = bus.i_pc;
        decOp.uses_rs1  = useRs1 && !bad;
        decOp.uses_rs2  = useRs2 && !bad;
        decOp.writes_rd = hasRd && (instr[11:7] != 5'd0) && !bad;
        decOp.illegal   = bad;
    end

    assign accept = bus.i_valid && !skidValid_q;
    assign drain  = outValid_q && bus.i_ready;

    // Flush wins over everything; otherwise skid refills output before new ops are taken.
    always_comb begin
        outValid_d  = outValid_q;
        skidValid_d = skidValid_q;
        outOp_d     = outOp_q;
        skidOp_d    = skidOp_q;
        if (bus.i_flush) begin
            outValid_d  = 1'b0;
            skidValid_d = 1'b0;
        end else if (!outValid_q || drain) begin
            if (skidValid_q) begin
                outOp_d     = skidOp_q;
                outValid_d  = 1'b1;
                skidValid_d = 1'b0;
            end else begin
                outValid_d = accept;
                if (accept) outOp_d = decOp;
            end
        end else if (accept) begin
            skidOp_d    = decOp;
            skidValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q  <= 1'b0;
            skidValid_q <= 1'b0;
            outOp_q     <= '0;
            skidOp_q    <= '0;
        end else begin
            outValid_q  <= outValid_d;
            skidValid_q <= skidValid_d;
            outOp_q     <= outOp_d;
            skidOp_q    <= skidOp_d;
        end
    end

    assign bus.o_ready = !skidValid_q;
    assign bus.o_valid = outValid_q;
    assign bus.o_op    = outOp_q;

    for (genvar p = 0; p < N_RD_PORTS; p++) begin : g_rdAddr
        if (p == 0) begin : g_rs1
            assign bus.o_reg_rd_addr[p] = outOp_q.rs1[RW-1:0];
        end else if (p == 1) begin : g_rs2
            assign bus.o_reg_rd_addr[p] = outOp_q.rs2[RW-1:0];
        end else begin : g_rd
            assign bus.o_reg_rd_addr[p] = outOp_q.rd[RW-1:0];
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode values, skid/backpressure, flush and reset.
// A second instance runs with 16 registers and three read ports.

module tb_decode_stage;
    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;

    decode_stage_if #(.XLEN(32), .N_REGS(32), .N_RD_PORTS(2)) bus ();
    decode_stage_if #(.XLEN(32), .N_REGS(16), .N_RD_PORTS(3)) bus16 ();

    decode_stage #(.XLEN(32), .N_REGS(32), .N_RD_PORTS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    decode_stage #(.XLEN(32), .N_REGS(16), .N_RD_PORTS(3)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkCount++; if (bus.o_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %0b want 0", bus.o_valid); else passCount++;
        checkCount++; if (bus.o_ready !== 1'b1) $display("[TB] FAIL rst_ready: got %0b want 1", bus.o_ready); else passCount++;
        checkCount++; if (bus.o_op !== '0) $display("[TB] FAIL rst_op: got %h want 0", bus.o_op); else passCount++;
        checkCount++; if (bus.o_reg_rd_addr !== '0) $display("[TB] FAIL rst_addr: got %h want 0", bus.o_reg_rd_addr); else passCount++;
        rst = 1'b0;
        @(negedge clk);
        checkCount++; if (bus.o_ready !== 1'b1) $display("[TB] FAIL rst_ready_after: got %0b want 1", bus.o_ready); else passCount++;
        checkCount++; if (bus.o_valid !== 1'b0) $display("[TB] FAIL rst_valid_after: got %0b want 0", bus.o_valid); else passCount++;
    endtask

    task automatic test_addi;
        bus.i_ready = 1'b1; bus.i_valid = 1'b1; bus.i_instr = 32'hFFF00093; bus.i_pc = 32'h100;
        @(negedge clk);
        bus.i_valid = 1'b0;
        checkCount++; if (bus.o_valid !== 1'b1) $display("[TB] FAIL addi_valid: got %0b want 1", bus.o_valid); else passCount++;
        checkCount++; if (bus.o_op.instr !== INS_ADDI) $display("[TB] FAIL addi_instr: got %0d want %0d", bus.o_op.instr, INS_ADDI); else passCount++;
        checkCount++; if (bus.o_op.rd !== 5'd1 || bus.o_op.rs1 !== 5'd0) $display("[TB] FAIL addi_regs: got rd=%0d rs1=%0d want rd=1 rs1=0", bus.o_op.rd, bus.o_op.rs1); else passCount++;
        checkCount++; if (bus.o_op.imm !== 32'hFFFFFFFF) $display("[TB] FAIL addi_imm: got %h want ffffffff", bus.o_op.imm); else passCount++;
        checkCount++; if (bus.o_op.writes_rd !== 1'b1 || bus.o_op.illegal !== 1'b0) $display("[TB] FAIL addi_flags: got wr=%0b ill=%0b want wr=1 ill=0", bus.o_op.writes_rd, bus.o_op.illegal); else passCount++;
        checkCount++; if (bus.o_op.pc !== 32'h100) $display("[TB] FAIL addi_pc: got %h want 100", bus.o_op.pc); else passCount++;
        checkCount++; if (bus.o_reg_rd_addr[0] !== 5'd0 || bus.o_reg_rd_addr[1] !== 5'd31) $display("[TB] FAIL addi_rdaddr: got %0d,%0d want 0,31", bus.o_reg_rd_addr[0], bus.o_reg_rd_addr[1]); else passCount++;
        @(negedge clk);
        checkCount++; if (bus.o_valid !== 1'b0) $display("[TB] FAIL addi_drained: got %0b want 0", bus.o_valid); else passCount++;
    endtask

    task automatic test_lui_branch;
        bus.i_valid = 1'b1; bus.i_instr = 32'h123450B7; bus.i_pc = 32'h200;
        @(negedge clk);
        bus.i_instr = 32'hFE000EE3; bus.i_pc = 32'h204;
        checkCount++; if (bus.o_op.instr !== INS_LUI || bus.o_op.opclass !== CLS_LUI) $display("[TB] FAIL lui_instr: got %0d/%0d want %0d/%0d", bus.o_op.instr, bus.o_op.opclass, INS_LUI, CLS_LUI); else passCount++;
        checkCount++; if (bus.o_op.imm !== 32'h12345000) $display("[TB] FAIL lui_imm: got %h want 12345000", bus.o_op.imm); else passCount++;
        @(negedge clk);
        bus.i_valid = 1'b0;
        checkCount++; if (bus.o_op.instr !== INS_BEQ || bus.o_op.opclass !== CLS_BRANCH) $display("[TB] FAIL beq_instr: got %0d/%0d want %0d/%0d", bus.o_op.instr, bus.o_op.opclass, INS_BEQ, CLS_BRANCH); else passCount++;
        checkCount++; if (bus.o_op.imm !== 32'hFFFFFFFC) $display("[TB] FAIL beq_imm: got %h want fffffffc", bus.o_op.imm); else passCount++;
        checkCount++; if (bus.o_op.writes_rd !== 1'b0 || bus.o_op.uses_rs1 !== 1'b1 || bus.o_op.uses_rs2 !== 1'b1) $display("[TB] FAIL beq_flags: got wr=%0b u1=%0b u2=%0b want 0 1 1", bus.o_op.writes_rd, bus.o_op.uses_rs1, bus.o_op.uses_rs2); else passCount++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_instr = 32'h00100093;
        @(negedge clk);
        bus.i_instr = 32'h00200113;
        checkCount++; if (bus.o_ready !== 1'b1) $display("[TB] FAIL b2b_ready_one: got %0b want 1", bus.o_ready); else passCount++;
        @(negedge clk);
        bus.i_instr = 32'h00300193;
        checkCount++; if (bus.o_ready !== 1'b0) $display("[TB] FAIL b2b_ready_full: got %0b want 0", bus.o_ready); else passCount++;
        checkCount++; if (bus.o_op.rd !== 5'd1) $display("[TB] FAIL b2b_head: got rd=%0d want 1", bus.o_op.rd); else passCount++;
        @(negedge clk);
        checkCount++; if (bus.o_valid !== 1'b1 || bus.o_op.rd !== 5'd1 || bus.o_op.imm !== 32'd1) $display("[TB] FAIL b2b_hold: got v=%0b rd=%0d imm=%0d want 1 1 1", bus.o_valid, bus.o_op.rd, bus.o_op.imm); else passCount++;
        checkCount++; if (bus.o_ready !== 1'b0) $display("[TB] FAIL b2b_third_held: got %0b want 0", bus.o_ready); else passCount++;
        bus.i_ready = 1'b1;
        @(negedge clk);
        checkCount++; if (bus.o_valid !== 1'b1 || bus.o_op.rd !== 5'd2 || bus.o_op.imm !== 32'd2) $display("[TB] FAIL b2b_second: got v=%0b rd=%0d imm=%0d want 1 2 2", bus.o_valid, bus.o_op.rd, bus.o_op.imm); else passCount++;
        checkCount++; if (bus.o_ready !== 1'b1) $display("[TB] FAIL b2b_ready_free: got %0b want 1", bus.o_ready); else passCount++;
        @(negedge clk);
        bus.i_valid = 1'b0;
        checkCount++; if (bus.o_valid !== 1'b1 || bus.o_op.rd !== 5'd3 || bus.o_op.imm !== 32'd3) $display("[TB] FAIL b2b_third: got v=%0b rd=%0d imm=%0d want 1 3 3", bus.o_valid, bus.o_op.rd, bus.o_op.imm); else passCount++;
        @(negedge clk);
        checkCount++; if (bus.o_valid !== 1'b0) $display("[TB] FAIL b2b_empty: got %0b want 0", bus.o_valid); else passCount++;
    endtask

    task automatic test_mul;
        bus.i_valid = 1'b1; bus.i_instr = 32'h02208033;
        @(negedge clk);
        bus.i_valid = 1'b0;
        checkCount++; if (bus.o_valid !== 1'b1 || bus.o_op.rs1 !== 5'd1 || bus.o_op.rs2 !== 5'd2) $display("[TB] FAIL mul_regs: got v=%0b rs1=%0d rs2=%0d want 1 1 2", bus.o_valid, bus.o_op.rs1, bus.o_op.rs2); else passCount++;
        checkCount++; if (bus.o_op.writes_rd !== 1'b0) $display("[TB] FAIL mul_wr: got %0b want 0", bus.o_op.writes_rd); else passCount++;
`ifdef ARRISKV_RV32M_EN
        checkCount++; if (bus.o_op.instr !== INS_MUL || bus.o_op.illegal !== 1'b0) $display("[TB] FAIL mul_decode: got %0d ill=%0b want %0d ill=0", bus.o_op.instr, bus.o_op.illegal, INS_MUL); else passCount++;
`else
        checkCount++; if (bus.o_op.instr !== INS_NOP || bus.o_op.illegal !== 1'b1) $display("[TB] FAIL mul_illegal: got %0d ill=%0b want %0d ill=1", bus.o_op.instr, bus.o_op.illegal, INS_NOP); else passCount++;
`endif
        @(negedge clk);
    endtask

    task automatic test_illegal;
        bus.i_valid = 1'b1; bus.i_instr = 32'h00000000;
        @(negedge clk);
        bus.i_instr = 32'h4210D093;
        checkCount++; if (bus.o_valid !== 1'b1 || bus.o_op.illegal !== 1'b1 || bus.o_op.instr !== INS_NOP) $display("[TB] FAIL zero_illegal: got v=%0b ill=%0b ins=%0d want 1 1 0", bus.o_valid, bus.o_op.illegal, bus.o_op.instr); else passCount++;
        @(negedge clk);
        bus.i_instr = 32'h4010D093;
        checkCount++; if (bus.o_op.illegal !== 1'b1 || bus.o_op.writes_rd !== 1'b0) $display("[TB] FAIL srai_bit25: got ill=%0b wr=%0b want 1 0", bus.o_op.illegal, bus.o_op.writes_rd); else passCount++;
        @(negedge clk);
        bus.i_valid = 1'b0;
        checkCount++; if (bus.o_op.instr !== INS_SRAI || bus.o_op.illegal !== 1'b0 || bus.o_op.writes_rd !== 1'b1) $display("[TB] FAIL srai_legal: got ins=%0d ill=%0b wr=%0b want %0d 0 1", bus.o_op.instr, bus.o_op.illegal, bus.o_op.writes_rd, INS_SRAI); else passCount++;
        @(negedge clk);
    endtask

    task automatic test_regs16;
        bus16.i_valid = 1'b1; bus16.i_instr = 32'h01000093;
        @(negedge clk);
        bus16.i_instr = 32'h00000813;
        checkCount++; if (bus16.o_valid !== 1'b1 || bus16.o_op.illegal !== 1'b0 || bus16.o_op.instr !== INS_ADDI) $display("[TB] FAIL r16_legal: got v=%0b ill=%0b ins=%0d want 1 0 %0d", bus16.o_valid, bus16.o_op.illegal, bus16.o_op.instr, INS_ADDI); else passCount++;
        checkCount++; if (bus16.o_op.imm !== 32'd16 || bus16.o_op.rd !== 5'd1) $display("[TB] FAIL r16_fields: got imm=%0d rd=%0d want 16 1", bus16.o_op.imm, bus16.o_op.rd); else passCount++;
        checkCount++; if (bus16.o_reg_rd_addr[2] !== 4'd1 || bus16.o_reg_rd_addr[0] !== 4'd0) $display("[TB] FAIL r16_rdaddr: got rd=%0d rs1=%0d want 1 0", bus16.o_reg_rd_addr[2], bus16.o_reg_rd_addr[0]); else passCount++;
        @(negedge clk);
        bus16.i_valid = 1'b0;
        checkCount++; if (bus16.o_op.illegal !== 1'b1 || bus16.o_op.writes_rd !== 1'b0 || bus16.o_op.instr !== INS_NOP) $display("[TB] FAIL r16_x16: got ill=%0b wr=%0b ins=%0d want 1 0 0", bus16.o_op.illegal, bus16.o_op.writes_rd, bus16.o_op.instr); else passCount++;
        @(negedge clk);
    endtask

    task automatic test_flush_reset;
        bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_instr = 32'h00100093;
        @(negedge clk);
        bus.i_instr = 32'h00200113;
        @(negedge clk);
        checkCount++; if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0) $display("[TB] FAIL flush_full: got v=%0b r=%0b want 1 0", bus.o_valid, bus.o_ready); else passCount++;
        bus.i_flush = 1'b1; bus.i_instr = 32'h00300193;
        @(negedge clk);
        checkCount++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) $display("[TB] FAIL flush_clear: got v=%0b r=%0b want 0 1", bus.o_valid, bus.o_ready); else passCount++;
        @(negedge clk);
        checkCount++; if (bus.o_valid !== 1'b0) $display("[TB] FAIL flush_drop: got %0b want 0", bus.o_valid); else passCount++;
        bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkCount++; if (bus.o_valid !== 1'b0) $display("[TB] FAIL flush_stale%0d: got %0b want 0", i, bus.o_valid); else passCount++;
        end

        bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_instr = 32'h00100093;
        @(negedge clk);
        bus.i_instr = 32'h00200113;
        @(negedge clk);
        checkCount++; if (bus.o_ready !== 1'b0) $display("[TB] FAIL rst_stall_full: got %0b want 0", bus.o_ready); else passCount++;
        #2 rst = 1'b1;
        #1;
        checkCount++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) $display("[TB] FAIL rst_async: got v=%0b r=%0b want 0 1", bus.o_valid, bus.o_ready); else passCount++;
        checkCount++; if (bus.o_op !== '0) $display("[TB] FAIL rst_async_op: got %h want 0", bus.o_op); else passCount++;
        @(negedge clk);
        rst = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkCount++; if (bus.o_valid !== 1'b0) $display("[TB] FAIL rst_stale%0d: got %0b want 0", i, bus.o_valid); else passCount++;
        end
        bus.i_valid = 1'b1; bus.i_instr = 32'h00500293;
        @(negedge clk);
        bus.i_valid = 1'b0;
        checkCount++; if (bus.o_valid !== 1'b1 || bus.o_op.rd !== 5'd5 || bus.o_op.imm !== 32'd5) $display("[TB] FAIL rst_first_op: got v=%0b rd=%0d imm=%0d want 1 5 5", bus.o_valid, bus.o_op.rd, bus.o_op.imm); else passCount++;
        @(negedge clk);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_instr = '0; bus.i_pc = '0; bus.i_ready = 1'b1; bus.i_flush = 1'b0;
        bus16.i_valid = 1'b0; bus16.i_instr = '0; bus16.i_pc = '0; bus16.i_ready = 1'b1; bus16.i_flush = 1'b0;
        test_reset();
        test_addi();
        test_lui_branch();
        test_back_to_back();
        test_mul();
        test_illegal();
        test_regs16();
        test_flush_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
